// File: rtl/instr_word_encoder.sv
// Encodes ARM instruction descriptors into 32-bit words and writes them
// into instruction memory at consecutive addresses.
module instr_word_encoder #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_cmd,
  input  logic              in_i,
  input  logic              in_s,
  input  logic              in_l,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rm,
  input  logic [11:0]       in_imm,
  input  logic [23:0]       in_off24,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX =
    (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] BASE =
    ADDR_W'(BASE_ADDR);

  localparam logic [1:0] K_DP  = 2'b00;
  localparam logic [1:0] K_MEM = 2'b01;
  localparam logic [1:0] K_B   = 2'b10;

  localparam logic [1:0] E_CMD  = 2'b01;
  localparam logic [1:0] E_KIND = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       word_q, word_d;
  logic              last_q, last_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic              done_q, done_d;

  logic              kind_ok;
  logic              cmd_ok;
  logic              legal;
  logic              accept;
  logic              start_ok;
  logic              wr_end;
  logic [11:0]       src2;
  logic [31:0]       enc;

  always_comb begin
    kind_ok = (in_kind != 2'b11);
    cmd_ok  = 1'b1;
    if (in_kind == K_DP) begin
      unique case (in_cmd)
        4'b0100,
        4'b0010,
        4'b0000,
        4'b1100: cmd_ok = 1'b1;
        default: cmd_ok = 1'b0;
      endcase
    end
    legal = kind_ok && cmd_ok;
  end

  assign accept   = (state_q == S_ACCEPT) && in_valid;
  assign start_ok = start &&
    ((state_q == S_IDLE) || (state_q == S_DONE));
  assign wr_end   = last_q || (count_q == CNT_MAX);

  // MEM: P=1 U=1 B=0 W=0; register offset when I is clear
  always_comb begin
    src2 = in_i ? in_imm : {8'h00, in_rm};
    enc  = 32'h0;
    unique case (in_kind)
      K_DP: enc = {in_cond, 2'b00, in_i, in_cmd,
                   in_s, in_rn, in_rd, src2};
      K_MEM: enc = {in_cond, 2'b01, ~in_i,
                    4'b1100, in_l, in_rn,
                    in_rd, src2};
      K_B: enc = {in_cond, 4'b1010, in_off24};
      default: enc = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ACCEPT;
      end
      S_ACCEPT: begin
        if (in_valid) begin
          if (legal)        state_d = S_WRITE;
          else if (in_last) state_d = S_DONE;
        end
      end
      S_WRITE: begin
        state_d = wr_end ? S_DONE : S_ACCEPT;
      end
      S_DONE: begin
        if (start) state_d = S_ACCEPT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_ACCEPT);
    busy     = (state_q == S_ACCEPT) ||
               (state_q == S_WRITE);
    mem_we   = (state_q == S_WRITE);
    mem_addr = '0;
    if (state_q == S_WRITE) begin
      mem_addr = BASE + count_q[ADDR_W-1:0];
    end
  end

  always_comb begin
    word_d  = word_q;
    last_d  = last_q;
    count_d = count_q;
    full_d  = full_q;
    err_d   = err_q;
    code_d  = code_q;
    if (start_ok) begin
      count_d = '0;
      full_d  = 1'b0;
      err_d   = 1'b0;
      code_d  = 2'b00;
    end
    if (accept && legal) begin
      word_d = enc;
      last_d = in_last;
    end
    // only the first error code survives until the next start
    if (accept && !legal) begin
      err_d = 1'b1;
      if (!err_q) code_d = kind_ok ? E_CMD : E_KIND;
    end
    if (state_q == S_WRITE) begin
      count_d = count_q + 1'b1;
      if (count_q == CNT_MAX) full_d = 1'b1;
    end
    done_d = (state_d == S_DONE) &&
             (state_q != S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q  <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      word_q  <= word_d;
      last_q  <= last_d;
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
      code_q  <= code_d;
      done_q  <= done_d;
    end
  end

  assign mem_wdata = word_q;
  assign count     = count_q;
  assign full      = full_q;
  assign err       = err_q;
  assign err_code  = code_q;
  assign done      = done_q;

endmodule

// File: tb/tb_instr_word_encoder.sv
// Directed bench for instr_word_encoder: default-depth load
// plus a 4-deep instance for the full condition.
module tb_instr_word_encoder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  kind;
  logic [3:0]  cond, cmd, rn, rd, rm;
  logic        ii, ss, ll, last;
  logic [11:0] imm;
  logic [23:0] off;

  logic        start1 = 1'b0, vld1 = 1'b0;
  logic        rdy1, we1, busy1, done1, full1, err1;
  logic [5:0]  addr1;
  logic [31:0] wd1;
  logic [6:0]  cnt1;
  logic [1:0]  code1;

  logic        start2 = 1'b0, vld2 = 1'b0;
  logic        rdy2, we2, busy2, done2, full2, err2;
  logic [1:0]  addr2;
  logic [31:0] wd2;
  logic [2:0]  cnt2;
  logic [1:0]  code2;

  instr_word_encoder #(.ADDR_W(6), .BASE_ADDR(0)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start1),
    .in_valid(vld1), .in_ready(rdy1), .in_kind(kind),
    .in_cond(cond), .in_cmd(cmd), .in_i(ii), .in_s(ss),
    .in_l(ll), .in_rn(rn), .in_rd(rd), .in_rm(rm),
    .in_imm(imm), .in_off24(off), .in_last(last),
    .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
    .count(cnt1), .busy(busy1), .done(done1),
    .full(full1), .err(err1), .err_code(code1));

  instr_word_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u2 (
    .clk(clk), .reset_n(reset_n), .start(start2),
    .in_valid(vld2), .in_ready(rdy2), .in_kind(kind),
    .in_cond(cond), .in_cmd(cmd), .in_i(ii), .in_s(ss),
    .in_l(ll), .in_rn(rn), .in_rd(rd), .in_rm(rm),
    .in_imm(imm), .in_off24(off), .in_last(last),
    .mem_we(we2), .mem_addr(addr2), .mem_wdata(wd2),
    .count(cnt2), .busy(busy2), .done(done2),
    .full(full2), .err(err2), .err_code(code2));

  typedef struct {
    logic [1:0]  kind;
    logic [3:0]  cond, cmd;
    logic        i, s, l;
    logic [3:0]  rn, rd, rm;
    logic [11:0] imm;
    logic [23:0] off;
    logic        last;
    logic        we;
    logic [31:0] word;
    logic [5:0]  addr;
    logic [6:0]  cnt;
    logic        err;
    logic [1:0]  code;
  } vec_t;

  localparam int NV = 10;
  vec_t vec [NV];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int sel);
    int n;
    n = 0;
    while (!(sel == 1 ? rdy2 : rdy1) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic drive(input vec_t v);
    kind = v.kind; cond = v.cond; cmd = v.cmd;
    ii = v.i; ss = v.s; ll = v.l;
    rn = v.rn; rd = v.rd; rm = v.rm;
    imm = v.imm; off = v.off; last = v.last;
  endtask

  task automatic pulse_start(input int sel);
    if (sel == 1) start2 = 1'b1;
    else          start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  initial begin
    vec[0] = '{2'b00, 4'hE, 4'h4, 1'b1, 1'b0, 1'b0,
               4'd2, 4'd1, 4'd0, 12'h005, 24'h0, 1'b0,
               1'b1, 32'hE2821005, 6'd0, 7'd1, 1'b0, 2'b00};
    vec[1] = '{2'b00, 4'hE, 4'h2, 1'b0, 1'b1, 1'b0,
               4'd4, 4'd3, 4'd5, 12'h000, 24'h0, 1'b0,
               1'b1, 32'hE0543005, 6'd1, 7'd2, 1'b0, 2'b00};
    vec[2] = '{2'b01, 4'hE, 4'h0, 1'b1, 1'b0, 1'b1,
               4'd1, 4'd0, 4'd0, 12'h008, 24'h0, 1'b0,
               1'b1, 32'hE5910008, 6'd2, 7'd3, 1'b0, 2'b00};
    vec[3] = '{2'b01, 4'hE, 4'h0, 1'b1, 1'b0, 1'b0,
               4'd1, 4'd0, 4'd0, 12'h008, 24'h0, 1'b0,
               1'b1, 32'hE5810008, 6'd3, 7'd4, 1'b0, 2'b00};
    vec[4] = '{2'b00, 4'hE, 4'hC, 1'b0, 1'b0, 1'b0,
               4'd0, 4'd15, 4'd1, 12'h000, 24'h0, 1'b0,
               1'b1, 32'hE180F001, 6'd4, 7'd5, 1'b0, 2'b00};
    vec[5] = '{2'b00, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0,
               4'd3, 4'd4, 4'd0, 12'hFFF, 24'h0, 1'b0,
               1'b1, 32'h02134FFF, 6'd5, 7'd6, 1'b0, 2'b00};
    vec[6] = '{2'b00, 4'hE, 4'hF, 1'b1, 1'b0, 1'b0,
               4'd1, 4'd1, 4'd0, 12'h001, 24'h0, 1'b0,
               1'b0, 32'h0, 6'd0, 7'd6, 1'b1, 2'b01};
    vec[7] = '{2'b11, 4'hE, 4'h4, 1'b1, 1'b0, 1'b0,
               4'd1, 4'd1, 4'd0, 12'h001, 24'h0, 1'b0,
               1'b0, 32'h0, 6'd0, 7'd6, 1'b1, 2'b01};
    vec[8] = '{2'b01, 4'hE, 4'h0, 1'b0, 1'b0, 1'b1,
               4'd2, 4'd3, 4'd4, 12'h000, 24'h0, 1'b0,
               1'b1, 32'hE7923004, 6'd6, 7'd7, 1'b1, 2'b01};
    vec[9] = '{2'b10, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0,
               4'd0, 4'd0, 4'd0, 12'h000, 24'h000002, 1'b1,
               1'b1, 32'hEA000002, 6'd7, 7'd8, 1'b1, 2'b01};

    drive(vec[0]);
    #2;
    chk("rst_we", we1, 0);
    chk("rst_ready", rdy1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_count", cnt1, 0);
    chk("rst_wdata", wd1, 0);
    chk("rst_err", {err1, code1, done1, full1}, 0);
    #10 reset_n = 1'b1;
    tick();

    pulse_start(0);
    chk("start_ready", rdy1, 1);
    for (int k = 0; k < NV; k++) begin
      wait_ready(0);
      drive(vec[k]);
      vld1 = 1'b1;
      tick();
      vld1 = 1'b0;
      chk($sformatf("v%0d_we", k), we1, vec[k].we);
      if (vec[k].we) begin
        chk($sformatf("v%0d_word", k), wd1, vec[k].word);
        chk($sformatf("v%0d_addr", k), addr1, vec[k].addr);
      end
      tick();
      chk($sformatf("v%0d_count", k), cnt1, vec[k].cnt);
      chk($sformatf("v%0d_err", k), err1, vec[k].err);
      chk($sformatf("v%0d_code", k), code1, vec[k].code);
    end
    chk("last_done", done1, 1);
    chk("last_busy", busy1, 0);
    chk("last_ready", rdy1, 0);
    tick();
    chk("done_pulse", done1, 0);

    pulse_start(0);
    chk("restart_count", cnt1, 0);
    chk("restart_err", err1, 0);
    chk("restart_code", code1, 0);
    chk("restart_busy", busy1, 1);

    pulse_start(1);
    for (int j = 0; j < 4; j++) begin
      wait_ready(1);
      drive(vec[j]);
      vld2 = 1'b1;
      tick();
      vld2 = 1'b0;
      chk($sformatf("f%0d_we", j), we2, 1);
      chk($sformatf("f%0d_addr", j), addr2, j);
      chk($sformatf("f%0d_word", j), wd2, vec[j].word);
      tick();
      if (j == 1) begin
        pulse_start(1);
        chk("busy_start_count", cnt2, 2);
        chk("busy_start_busy", busy2, 1);
      end
    end
    chk("full_count", cnt2, 4);
    chk("full_flag", full2, 1);
    chk("full_done", done2, 1);
    chk("full_ready", rdy2, 0);
    tick();
    chk("full_done_pulse", done2, 0);
    chk("full_stays", full2, 1);
    pulse_start(1);
    chk("full_cleared", full2, 0);
    chk("full_cnt_cleared", cnt2, 0);

    wait_ready(0);
    drive(vec[0]);
    vld1 = 1'b1;
    tick();
    vld1 = 1'b0;
    chk("pre_rst_we", we1, 1);
    reset_n = 1'b0;
    #1;
    chk("async_we", we1, 0);
    chk("async_count", cnt1, 0);
    chk("async_busy", busy1, 0);
    #2 reset_n = 1'b1;
    tick();
    chk("idle_ready", rdy1, 0);
    pulse_start(0);
    wait_ready(0);
    drive(vec[1]);
    vld1 = 1'b1;
    tick();
    vld1 = 1'b0;
    chk("after_rst_we", we1, 1);
    chk("after_rst_addr", addr1, 0);
    chk("after_rst_word", wd1, 32'hE0543005);
    tick();
    chk("after_rst_count", cnt1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
